regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Write-side driver for RegFile: collects completed results from the ALU and load
//  (MEM) paths, buffers them in a small in-order queue, and issues at most one
//  register write per cycle on the RegFile write_enable/write_addr/write_data_in port.
//  Also reports per-register "write pending" status so decode can stall on RAW hazards.
// PARAMETERS
//  XLEN        32  data width of a register
//  REG_ADDR_W  5   register index width (32 registers, x0 hardwired to zero)
//  DEPTH       4   queue entries; power of 2, >= 2
// PORTS
//  clk            in   1           system clock, rising edge
//  reset          in   1           synchronous, active-high
//  alu_valid      in   1           ALU result offered
//  alu_rd         in   REG_ADDR_W  ALU destination register
//  alu_data       in   XLEN        ALU result
//  mem_valid      in   1           load result offered
//  mem_rd         in   REG_ADDR_W  load destination register
//  mem_data       in   XLEN        load result
//  src_ready      out  1           both sources may push this cycle
//  wb_stall       in   1           RegFile write port unavailable; hold queue head
//  write_enable   out  1           to RegFile write_enable
//  write_addr     out  REG_ADDR_W  to RegFile write_addr
//  write_data_in  out  XLEN        to RegFile write_data_in
//  query_addr1    in   REG_ADDR_W  decode rs1 lookup
//  query_addr2    in   REG_ADDR_W  decode rs2 lookup
//  pending1       out  1           queued write targets query_addr1
//  pending2       out  1           queued write targets query_addr2
// BEHAVIOUR
//  - Storage: circular queue of {rd, data}; rd_ptr, wr_ptr (log2 DEPTH bits, wrap
//    modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH).
//  - src_ready = (count <= DEPTH-2); registered-state function, not dependent on pop.
//  - Push: alu accepted when alu_valid & src_ready; mem when mem_valid & src_ready.
//    Both in one cycle -> ALU entry enqueued first, MEM entry second (2 pushes).
//  - rd == 0: handshake completes but entry is NOT enqueued (write to x0 dropped).
//  - Output: write_enable = (count != 0) & ~wb_stall; write_addr/write_data_in = head
//    entry (driven from registers, no combinational path from source inputs).
//  - Pop: when write_enable = 1, head is retired at that clock edge (RegFile captures
//    same edge). Push and pop in same cycle allowed; count += pushes - pop.
//  - Latency: result accepted at edge N with empty queue -> write_enable high during
//    cycle N+1, register updated at edge ending N+1.
//  - wb_stall = 1: no pop, write_enable = 0, head/addr/data held stable.
//  - pendingK = (query_addrK != 0) & any valid queue entry has rd == query_addrK
//    (head included, incoming pushes this cycle excluded). Combinational.
//  - Reset (any time, incl. mid-burst): pointers/count = 0, queued writes discarded,
//    write_enable = 0, write_addr = 0, write_data_in = 0, pending1/2 = 0,
//    src_ready = 1 in first cycle after reset.
//  - Never overflow: count must not exceed DEPTH; never pop when empty.
// TESTING
//  1 reset pulse -> write_enable=0, addr/data=0, src_ready=1, pending1/2=0.
//  2 ALU rd=2 data=4000000 one cycle -> next cycle write_enable=1 addr=2 data=4000000
//    for exactly one cycle; RegFile read x2 returns 4000000.
//  3 same cycle ALU rd=7/26794 and MEM rd=25/588890 -> writes x7 then x25 on two
//    consecutive cycles; query_addr1=25 gives pending1=1 until x25 write cycle ends.
//  4 ALU rd=0 data=4096 -> accepted, write_enable stays 0, x0 still reads 0.
//  5 wb_stall=1, both sources valid every cycle -> count 0,2,4; src_ready drops at
//    count=4; release stall -> 4 writes in push order, src_ready back at count<=2.
//  6 reset asserted with 3 queued -> next cycle write_enable=0, count=0, no stale write.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the RegFile write port: merges ALU and load
// results, retires at most one per cycle, and flags queued destinations for hazard checks.
module regfile_writeback_queue #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  src_ready,
    input  logic                  wb_stall,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [XLEN-1:0]       write_data_in,
    input  logic [REG_ADDR_W-1:0] query_addr1,
    input  logic [REG_ADDR_W-1:0] query_addr2,
    output logic                  pending1,
    output logic                  pending2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             alu_push;
    logic             mem_push;
    logic             pop;
    logic             not_empty;
    logic [PTR_W-1:0] mem_slot;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    // Room for two pushes is guaranteed whenever src_ready is high, so no overflow check.
    assign src_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign not_empty = (count_q != '0);

    // Writes to x0 complete the handshake but are never queued.
    assign alu_push = alu_valid & src_ready & (alu_rd != '0);
    assign mem_push = mem_valid & src_ready & (mem_rd != '0);
    assign mem_slot = wr_ptr_q + PTR_W'(alu_push);

    assign write_enable  = not_empty & ~wb_stall;
    assign pop           = write_enable;
    assign write_addr    = not_empty ? rd_q[rd_ptr_q] : '0;
    assign write_data_in = not_empty ? data_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(alu_push) + PTR_W'(mem_push);
        count_d  = count_q + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && alu_push) begin
            rd_q[wr_ptr_q]   <= alu_rd;
            data_q[wr_ptr_q] <= alu_data;
        end
        if (!reset && mem_push) begin
            rd_q[mem_slot]   <= mem_rd;
            data_q[mem_slot] <= mem_data;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        match1      = '0;
        match2      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
            match1[i]      = (rd_q[i] == query_addr1);
            match2[i]      = (rd_q[i] == query_addr2);
        end
    end

    assign pending1 = (query_addr1 != '0) & (|(entry_valid & match1));
    assign pending2 = (query_addr2 != '0) & (|(entry_valid & match2));

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue; a small RegFile model captures the
// write port so register contents can be checked against hand-computed values.
module tb_regfile_writeback_queue;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        src_ready;
    logic        wb_stall;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data_in;
    logic [4:0]  query_addr1;
    logic [4:0]  query_addr2;
    logic        pending1;
    logic        pending2;

    logic [31:0] rf [32];

    int checks;
    int passed;

    regfile_writeback_queue #(
        .XLEN      (32),
        .REG_ADDR_W(5),
        .DEPTH     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .src_ready    (src_ready),
        .wb_stall     (wb_stall),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data_in(write_data_in),
        .query_addr1  (query_addr1),
        .query_addr2  (query_addr2),
        .pending1     (pending1),
        .pending2     (pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RegFile model: captures whatever the port writes, x0 included, so a stray x0 write shows.
    always @(posedge clk) begin
        if (write_enable) rf[write_addr] <= write_data_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sources();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        wb_stall    = 1'b0;
        query_addr1 = 5'd3;
        query_addr2 = 5'd0;
        idle_sources();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (write_enable !== 1'b0) $display("FAIL reset_we got %b want 0", write_enable); else passed++;
        checks++; if (write_addr !== 5'd0) $display("FAIL reset_addr got %0d want 0", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd0) $display("FAIL reset_data got %0d want 0", write_data_in); else passed++;
        checks++; if (src_ready !== 1'b1) $display("FAIL reset_src_ready got %b want 1", src_ready); else passed++;
        checks++; if (pending1 !== 1'b0) $display("FAIL reset_pending1 got %b want 0", pending1); else passed++;
        checks++; if (pending2 !== 1'b0) $display("FAIL reset_pending2 got %b want 0", pending2); else passed++;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'd4000000;
        tick();
        idle_sources();
        checks++; if (write_enable !== 1'b1) $display("FAIL single_we got %b want 1", write_enable); else passed++;
        checks++; if (write_addr !== 5'd2) $display("FAIL single_addr got %0d want 2", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd4000000) $display("FAIL single_data got %0d want 4000000", write_data_in); else passed++;
        tick();
        checks++; if (write_enable !== 1'b0) $display("FAIL single_we_after got %b want 0", write_enable); else passed++;
        checks++; if (rf[2] !== 32'd4000000) $display("FAIL single_rf_x2 got %0d want 4000000", rf[2]); else passed++;
    endtask

    task automatic test_dual_source();
        query_addr1 = 5'd25;
        query_addr2 = 5'd7;
        alu_valid   = 1'b1;
        alu_rd      = 5'd7;
        alu_data    = 32'd26794;
        mem_valid   = 1'b1;
        mem_rd      = 5'd25;
        mem_data    = 32'd588890;
        checks++; if (pending1 !== 1'b0) $display("FAIL dual_pending1_before got %b want 0", pending1); else passed++;
        tick();
        idle_sources();
        checks++; if (pending1 !== 1'b1) $display("FAIL dual_pending1_c1 got %b want 1", pending1); else passed++;
        checks++; if (pending2 !== 1'b1) $display("FAIL dual_pending2_c1 got %b want 1", pending2); else passed++;
        checks++; if (write_enable !== 1'b1) $display("FAIL dual_we_c1 got %b want 1", write_enable); else passed++;
        checks++; if (write_addr !== 5'd7) $display("FAIL dual_addr_c1 got %0d want 7", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd26794) $display("FAIL dual_data_c1 got %0d want 26794", write_data_in); else passed++;
        tick();
        checks++; if (pending1 !== 1'b1) $display("FAIL dual_pending1_c2 got %b want 1", pending1); else passed++;
        checks++; if (pending2 !== 1'b0) $display("FAIL dual_pending2_c2 got %b want 0", pending2); else passed++;
        checks++; if (write_enable !== 1'b1) $display("FAIL dual_we_c2 got %b want 1", write_enable); else passed++;
        checks++; if (write_addr !== 5'd25) $display("FAIL dual_addr_c2 got %0d want 25", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd588890) $display("FAIL dual_data_c2 got %0d want 588890", write_data_in); else passed++;
        tick();
        checks++; if (pending1 !== 1'b0) $display("FAIL dual_pending1_c3 got %b want 0", pending1); else passed++;
        checks++; if (write_enable !== 1'b0) $display("FAIL dual_we_c3 got %b want 0", write_enable); else passed++;
        checks++; if (rf[7] !== 32'd26794) $display("FAIL dual_rf_x7 got %0d want 26794", rf[7]); else passed++;
        checks++; if (rf[25] !== 32'd588890) $display("FAIL dual_rf_x25 got %0d want 588890", rf[25]); else passed++;
    endtask

    task automatic test_x0_drop();
        query_addr1 = 5'd0;
        query_addr2 = 5'd0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd0;
        alu_data    = 32'd4096;
        checks++; if (src_ready !== 1'b1) $display("FAIL x0_src_ready got %b want 1", src_ready); else passed++;
        tick();
        idle_sources();
        checks++; if (write_enable !== 1'b0) $display("FAIL x0_we_c1 got %b want 0", write_enable); else passed++;
        checks++; if (pending1 !== 1'b0) $display("FAIL x0_pending1 got %b want 0", pending1); else passed++;
        tick();
        checks++; if (write_enable !== 1'b0) $display("FAIL x0_we_c2 got %b want 0", write_enable); else passed++;
        checks++; if (rf[0] !== 32'd0) $display("FAIL x0_rf_x0 got %0d want 0", rf[0]); else passed++;
    endtask

    task automatic test_stall_burst();
        wb_stall    = 1'b1;
        query_addr1 = 5'd1;
        query_addr2 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd101;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'd303;
        checks++; if (src_ready !== 1'b1) $display("FAIL stall_ready_c0 got %b want 1", src_ready); else passed++;
        tick();
        alu_rd = 5'd4; alu_data = 32'd404;
        mem_rd = 5'd5; mem_data = 32'd505;
        checks++; if (src_ready !== 1'b1) $display("FAIL stall_ready_c2 got %b want 1", src_ready); else passed++;
        checks++; if (write_enable !== 1'b0) $display("FAIL stall_we_c2 got %b want 0", write_enable); else passed++;
        checks++; if (pending2 !== 1'b0) $display("FAIL stall_pending2_c2 got %b want 0", pending2); else passed++;
        tick();
        // Offered while full: these must be refused.
        alu_rd = 5'd6; alu_data = 32'd606;
        mem_rd = 5'd8; mem_data = 32'd808;
        checks++; if (src_ready !== 1'b0) $display("FAIL stall_ready_c4 got %b want 0", src_ready); else passed++;
        checks++; if (write_enable !== 1'b0) $display("FAIL stall_we_c4 got %b want 0", write_enable); else passed++;
        checks++; if (write_addr !== 5'd1) $display("FAIL stall_head_addr got %0d want 1", write_addr); else passed++;
        checks++; if (pending1 !== 1'b1) $display("FAIL stall_pending1 got %b want 1", pending1); else passed++;
        checks++; if (pending2 !== 1'b1) $display("FAIL stall_pending2 got %b want 1", pending2); else passed++;
        tick();
        idle_sources();
        checks++; if (write_addr !== 5'd1) $display("FAIL stall_hold_addr got %0d want 1", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd101) $display("FAIL stall_hold_data got %0d want 101", write_data_in); else passed++;
        wb_stall = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b1) $display("FAIL drain_we_1 got %b want 1", write_enable); else passed++;
        checks++; if (src_ready !== 1'b0) $display("FAIL drain_ready_1 got %b want 0", src_ready); else passed++;
        tick();
        checks++; if (write_addr !== 5'd3) $display("FAIL drain_addr_2 got %0d want 3", write_addr); else passed++;
        checks++; if (src_ready !== 1'b0) $display("FAIL drain_ready_2 got %b want 0", src_ready); else passed++;
        tick();
        checks++; if (write_addr !== 5'd4) $display("FAIL drain_addr_3 got %0d want 4", write_addr); else passed++;
        checks++; if (src_ready !== 1'b1) $display("FAIL drain_ready_3 got %b want 1", src_ready); else passed++;
        tick();
        checks++; if (write_addr !== 5'd5) $display("FAIL drain_addr_4 got %0d want 5", write_addr); else passed++;
        checks++; if (write_data_in !== 32'd505) $display("FAIL drain_data_4 got %0d want 505", write_data_in); else passed++;
        tick();
        checks++; if (write_enable !== 1'b0) $display("FAIL drain_we_end got %b want 0", write_enable); else passed++;
        checks++; if (rf[1] !== 32'd101) $display("FAIL drain_rf_x1 got %0d want 101", rf[1]); else passed++;
        checks++; if (rf[3] !== 32'd303) $display("FAIL drain_rf_x3 got %0d want 303", rf[3]); else passed++;
        checks++; if (rf[4] !== 32'd404) $display("FAIL drain_rf_x4 got %0d want 404", rf[4]); else passed++;
        checks++; if (rf[5] !== 32'd505) $display("FAIL drain_rf_x5 got %0d want 505", rf[5]); else passed++;
        checks++; if (rf[6] !== 32'd0) $display("FAIL refused_rf_x6 got %0d want 0", rf[6]); else passed++;
        checks++; if (rf[8] !== 32'd0) $display("FAIL refused_rf_x8 got %0d want 0", rf[8]); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        wb_stall    = 1'b1;
        query_addr1 = 5'd9;
        query_addr2 = 5'd11;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'd909;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'd1010;
        tick();
        mem_valid = 1'b0;
        alu_rd = 5'd11; alu_data = 32'd1111;
        tick();
        idle_sources();
        checks++; if (pending1 !== 1'b1) $display("FAIL midrst_pending1_pre got %b want 1", pending1); else passed++;
        checks++; if (src_ready !== 1'b0) $display("FAIL midrst_ready_pre got %b want 0", src_ready); else passed++;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        wb_stall = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b0) $display("FAIL midrst_we got %b want 0", write_enable); else passed++;
        checks++; if (write_addr !== 5'd0) $display("FAIL midrst_addr got %0d want 0", write_addr); else passed++;
        checks++; if (src_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", src_ready); else passed++;
        checks++; if (pending1 !== 1'b0) $display("FAIL midrst_pending1 got %b want 0", pending1); else passed++;
        checks++; if (pending2 !== 1'b0) $display("FAIL midrst_pending2 got %b want 0", pending2); else passed++;
        tick();
        tick();
        checks++; if (write_enable !== 1'b0) $display("FAIL midrst_we_later got %b want 0", write_enable); else passed++;
        checks++; if (rf[9] !== 32'd0) $display("FAIL midrst_rf_x9 got %0d want 0", rf[9]); else passed++;
        checks++; if (rf[10] !== 32'd0) $display("FAIL midrst_rf_x10 got %0d want 0", rf[10]); else passed++;
        checks++; if (rf[11] !== 32'd0) $display("FAIL midrst_rf_x11 got %0d want 0", rf[11]); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single_alu();
        test_dual_source();
        test_x0_drop();
        test_stall_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
